mc_ctrl: RTL

Multi-cycle sequencing controller for the MIPS datapath: one PC, IM, GRF, EXT, ALU and DM, with an instruction register (IR) between IM and decode. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and write strobe. Instructions take 2–5 cycles, so PC, GRF and DM each write at most once per instruction. It also counts retired instructions for the bench.

---
 rtl/mc_ctrl_pkg.sv | 73 +++++++
 rtl/mc_decode.sv | 33 +++
 rtl/mc_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BEQ  = 2'd1;
  localparam logic [1:0] NPC_JUMP = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  localparam logic [1:0] A3_RD    = 2'd0;
  localparam logic [1:0] A3_RT    = 2'd1;
  localparam logic [1:0] A3_RA    = 2'd2;

  localparam logic [1:0] DI_ALU   = 2'd0;
  localparam logic [1:0] DI_DM    = 2'd1;
  localparam logic [1:0] DI_PC4   = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  typedef enum logic [3:0] {
    IC_RCALC, IC_ORI, IC_LUI, IC_LW, IC_SW,
    IC_BEQ, IC_J, IC_JAL, IC_JR, IC_NOP
  } iclass_e;

  typedef struct packed {
    logic       ext_sign;
    logic [2:0] alu_op;
    logic       alu_b_op;
  } alu_sel_t;

  // ALU/EXT selects an instruction needs from EXEC onward; held through MEM
  // and WB so the address or result on ALU C does not move.
  function automatic alu_sel_t alu_sel(input iclass_e ic, input logic [5:0] funct);
    alu_sel_t s;
    s = '0;
    case (ic)
      IC_RCALC: s.alu_op = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      IC_ORI:   begin s.alu_op = ALU_OR;  s.alu_b_op = 1'b1; end
      IC_LUI:   begin s.alu_op = ALU_LUI; s.alu_b_op = 1'b1; end
      IC_LW,
      IC_SW:    begin s.ext_sign = 1'b1; s.alu_op = ALU_ADD; s.alu_b_op = 1'b1; end
      IC_BEQ:   s.alu_op = ALU_SUB;
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Classifies the IR {opcode, funct} pair into an instruction class.
// Latency: purely combinational.
// Backpressure: none; ports: opcode/funct in, iclass out.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    iclass
);

  always_comb begin
    iclass = IC_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: iclass = IC_RCALC;
          FN_JR:            iclass = IC_JR;
          default:          iclass = IC_NOP;
        endcase
      end
      OP_ORI:  iclass = IC_ORI;
      OP_LUI:  iclass = IC_LUI;
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  iclass = IC_BEQ;
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      default: iclass = IC_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving all datapath selects
// and strobes, plus a retired-instruction counter. Latency: 2-5 cycles/instr.
// Backpressure: none; outputs are Moore decode of state + IR, zeroed in reset.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  npc_op,
  output logic        grf_write,
  output logic [1:0]  grf_a3_op,
  output logic [1:0]  grf_di_op,
  output logic        ext_sign,
  output logic [2:0]  alu_op,
  output logic        alu_b_op,
  output logic        dm_write,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic [31:0] retire_cnt
);

  state_e      state_q, state_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  iclass_e     iclass;
  alu_sel_t    sel;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass)
  );

  assign sel = alu_sel(iclass, funct);

  always_comb begin
    state_d    = S_FETCH;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    npc_op     = NPC_PC4;
    grf_write  = 1'b0;
    grf_a3_op  = A3_RD;
    grf_di_op  = DI_ALU;
    ext_sign   = 1'b0;
    alu_op     = ALU_ADD;
    alu_b_op   = 1'b0;
    dm_write   = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          IC_J:   begin pc_write = 1'b1; npc_op = NPC_JUMP; instr_done = 1'b1; end
          IC_JR:  begin pc_write = 1'b1; npc_op = NPC_JR;   instr_done = 1'b1; end
          IC_NOP: begin pc_write = 1'b1; npc_op = NPC_PC4;  instr_done = 1'b1; end
          IC_JAL: state_d = S_WB;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        {ext_sign, alu_op, alu_b_op} = sel;
        case (iclass)
          IC_LW, IC_SW: state_d = S_MEM;
          IC_BEQ: begin
            pc_write   = 1'b1;
            npc_op     = NPC_BEQ;
            instr_done = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        {ext_sign, alu_op, alu_b_op} = sel;
        if (iclass == IC_SW) begin
          dm_write   = 1'b1;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        // sel is all-zero for jal, so holding it here is harmless for that case.
        {ext_sign, alu_op, alu_b_op} = sel;
        grf_write  = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        case (iclass)
          IC_JAL:   begin npc_op = NPC_JUMP; grf_a3_op = A3_RA; grf_di_op = DI_PC4; end
          IC_RCALC: begin grf_a3_op = A3_RD; grf_di_op = DI_ALU; end
          IC_LW:    begin grf_a3_op = A3_RT; grf_di_op = DI_DM;  end
          default:  begin grf_a3_op = A3_RT; grf_di_op = DI_ALU; end
        endcase
      end
      default: state_d = S_FETCH; // illegal codes: all outputs stay 0
    endcase

    // Reset gates outputs combinationally so no strobe can leak through in
    // the cycle reset is asserted, even before the state register reacts.
    if (!reset) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      npc_op     = NPC_PC4;
      grf_write  = 1'b0;
      grf_a3_op  = A3_RD;
      grf_di_op  = DI_ALU;
      ext_sign   = 1'b0;
      alu_op     = ALU_ADD;
      alu_b_op   = 1'b0;
      dm_write   = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign retire_cnt_d = retire_cnt_q + (instr_done ? 32'd1 : 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule
